bin_to_bcd_seq: RTL



---
 rtl/bcd_pkg.sv | 27 ++
 rtl/bin_to_bcd_seq_if.sv | 14 +
 rtl/bcd_add3.sv | 7 +
 rtl/bin_to_bcd_seq.sv | 109 ++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types, constants and sizing helper for bin_to_bcd_seq
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Number of decimal digits needed to represent 2^bin_w - 1.
    function automatic int min_digits(input int bin_w);
        longint unsigned max_v;
        int              d;
        max_v = (64'd1 << bin_w) - 64'd1;
        d     = 1;
        for (int i = 0; i < 20; i++) begin
            if (max_v >= 64'd10) begin
                max_v = max_v / 64'd10;
                d     = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// rtl/bin_to_bcd_seq_if.sv - start/result handshake bundle for bin_to_bcd_seq
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;

    modport master (output start, output bin, input busy, input done, input bcd);
    modport slave  (input start, input bin, output busy, output done, output bcd);
endinterface

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble nibble adjust: values >= 5 get +3
module bcd_add3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);
    assign o_nib = (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble converter; BIN2BCD_BLANK_EN enables leading-zero blanking
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    bin_to_bcd_seq_if.slave  bus
);
    localparam int SCR_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    if (BIN_W < 1 || BIN_W > 32) begin : g_bad_bin_w
        $error("bin_to_bcd_seq: BIN_W out of range 1..32");
    end
    if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
        $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
    end

    // Zero digits above the most significant nonzero digit become blank; units never blank.
    function automatic logic [SCR_W-1:0] blank_digits(input logic [SCR_W-1:0] scr);
        logic [SCR_W-1:0] res;
        res = scr;
`ifdef BIN2BCD_BLANK_EN
        begin
            logic lead;
            lead = 1'b1;
            for (int d = DIGITS - 1; d >= 1; d--) begin
                if (lead && scr[4*d +: 4] == 4'd0) res[4*d +: 4] = BCD_BLANK;
                else                                lead = 1'b0;
            end
        end
`endif
        return res;
    endfunction

    localparam logic [SCR_W-1:0] BCD_RST = blank_digits('0);

    state_t                   r_state;
    state_t                   w_next;
    logic [BIN_W-1:0]         r_shift;
    logic [SCR_W-1:0]         r_scratch;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_busy;
    logic                     r_done;
    logic [SCR_W-1:0]         r_bcd;
    logic [SCR_W-1:0]         w_adj;
    logic [SCR_W+BIN_W-1:0]   w_cat;
    logic [SCR_W-1:0]         w_bcd_blank;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_nib (r_scratch[4*g +: 4]),
            .o_nib (w_adj[4*g +: 4])
        );
    end

    assign w_cat       = {w_adj, r_shift} << 1;
    assign w_bcd_blank = blank_digits(r_scratch);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = SHIFT;
            SHIFT:   if (r_cnt == CNT_W'(1)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= BCD_RST;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);
            r_done  <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_shift   <= bus.bin;
                        r_scratch <= '0;
                        r_cnt     <= CNT_W'(BIN_W);
                    end
                end
                SHIFT: begin
                    r_scratch <= w_cat[BIN_W +: SCR_W];
                    r_shift   <= w_cat[BIN_W-1:0];
                    r_cnt     <= r_cnt - CNT_W'(1);
                end
                DONE:    r_bcd <= w_bcd_blank;
                default: ;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.bcd  = r_bcd;

endmodule
